// File: rtl/pipeline_pkg.sv
// Shared widths, bubble encoding and fetch-state enum for the front-end pipeline.
package pipeline_pkg;
   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;
   localparam int SKID_W  = INSTR_W + PC_W;

   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'hD503201F;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic [PC_W-1:0] pc_step(input logic [PC_W-1:0] pc);
      return pc + PC_W'(4);
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of instruction-memory, hazard-control and fetch-output signals.
interface fetch_stage_if;
   import pipeline_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_target;
   logic [INSTR_W-1:0] instr_out;
   logic [PC_W-1:0]    pc_out;
   logic               valid_out;

   modport master (
      output imem_req, imem_addr, instr_out, pc_out, valid_out,
      input  imem_ack, imem_rdata, stall, redirect, redirect_target
   );

   modport slave (
      input  imem_req, imem_addr, instr_out, pc_out, valid_out,
      output imem_ack, imem_rdata, stall, redirect, redirect_target
   );
endinterface

// File: rtl/fetch_skid_buffer.sv
// Parks one fetched {instruction, pc} pair while the downstream stage is stalled.
module fetch_skid_buffer
   import pipeline_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [SKID_W-1:0] i_data,
   output logic [SKID_W-1:0] o_data,
   output logic              o_valid
);

   logic [SKID_W-1:0] r_data;
   logic              r_valid;

   // Clear wins over load so a redirect always empties the buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: request/ack memory handshake, stall skid, and redirect drain.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
)(
   input logic           clk,
   input logic           reset,
   fetch_stage_if.master bus
);

   fetch_state_e       r_state, w_state_nxt;
   logic [PC_W-1:0]    r_pc, w_pc_nxt;
   logic [PC_W-1:0]    r_fetch_addr, w_fetch_addr_nxt;
   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_pc_out;
   logic               r_valid;

   logic               w_out_mem, w_out_skid, w_out_bubble;
   logic               w_skid_load, w_skid_clear;
   logic [SKID_W-1:0]  w_skid_data;
   logic               w_skid_valid;

   fetch_skid_buffer u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  ({bus.imem_rdata, r_fetch_addr}),
      .o_data  (w_skid_data),
      .o_valid (w_skid_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_REQ;
         r_pc         <= RESET_PC;
         r_fetch_addr <= RESET_PC;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_fetch_addr <= w_fetch_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_fetch_addr_nxt = r_fetch_addr;
      w_out_mem        = 1'b0;
      w_out_skid       = 1'b0;
      w_out_bubble     = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;
      case (r_state)
         ST_REQ: begin
            if (bus.redirect) begin
               w_pc_nxt     = bus.redirect_target;
               w_out_bubble = 1'b1;
               w_skid_clear = 1'b1;
               // Without ack the old request stays on the bus until memory answers.
               if (bus.imem_ack) begin
                  w_fetch_addr_nxt = bus.redirect_target;
                  w_state_nxt      = ST_REQ;
               end else begin
                  w_state_nxt      = ST_DRAIN;
               end
            end else if (bus.imem_ack) begin
               w_pc_nxt = pc_step(r_pc);
               if (bus.stall) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_out_mem        = 1'b1;
                  w_fetch_addr_nxt = pc_step(r_pc);
               end
            end else if (!bus.stall) begin
               w_out_bubble = 1'b1;
            end
         end
         ST_HOLD: begin
            if (bus.redirect) begin
               w_pc_nxt         = bus.redirect_target;
               w_fetch_addr_nxt = bus.redirect_target;
               w_out_bubble     = 1'b1;
               w_skid_clear     = 1'b1;
               w_state_nxt      = ST_REQ;
            end else if (!bus.stall) begin
               w_out_skid       = 1'b1;
               w_skid_clear     = 1'b1;
               w_fetch_addr_nxt = r_pc;
               w_state_nxt      = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (bus.redirect) begin
               w_pc_nxt     = bus.redirect_target;
               w_out_bubble = 1'b1;
               w_skid_clear = 1'b1;
            end
            if (bus.imem_ack) begin
               w_fetch_addr_nxt = bus.redirect ? bus.redirect_target : r_pc;
               w_state_nxt      = ST_REQ;
            end
         end
         default: begin
            w_state_nxt = ST_REQ;
         end
      endcase
   end

   // Fetch -> register-fetch pipeline register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr  <= NOP_INSTR;
         r_pc_out <= '0;
         r_valid  <= 1'b0;
      end else if (w_out_bubble) begin
         r_instr  <= NOP_INSTR;
         r_valid  <= 1'b0;
      end else if (w_out_mem) begin
         r_instr  <= bus.imem_rdata;
         r_pc_out <= r_fetch_addr;
         r_valid  <= 1'b1;
      end else if (w_out_skid) begin
         {r_instr, r_pc_out} <= w_skid_data;
         r_valid             <= w_skid_valid;
      end
   end

   assign bus.imem_req  = ~reset & (r_state != ST_HOLD);
   assign bus.imem_addr = r_fetch_addr;
   assign bus.instr_out = r_instr;
   assign bus.pc_out    = r_pc_out;
   assign bus.valid_out = r_valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'hD503201F: bubble encoding driven on instr_out when no instruction is valid.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 imem_req  output  1  instruction-memory request; high while a fetch is outstanding.
REQ-007 imem_addr  output  64  fetch address; stable while imem_req is high until imem_ack.
REQ-008 imem_ack  input  1  memory accepted the request and imem_rdata is valid this cycle; zero-wait ack in the request cycle is allowed.
REQ-009 imem_rdata  input  32  fetched instruction word; sampled only when imem_req and imem_ack are both high.
REQ-010 stall  input  1  hazard hold: output registers and PC must not advance.
REQ-011 redirect  input  1  branch/flush from a later stage; has priority over stall.
REQ-012 redirect_target  input  64  new PC, sampled when redirect is high.
REQ-013 instr_out  output  32  registered instruction feeding the register-fetch pipeline register.
REQ-014 pc_out  output  64  registered PC of instr_out.
REQ-015 valid_out  output  1  instr_out/pc_out hold a real instruction.

Function
REQ-016 The FSM SHALL have states REQ (fetch outstanding), HOLD (fetched word parked because of stall), and DRAIN (discarding a stale in-flight fetch after redirect).
REQ-017 imem_req SHALL be 1 in REQ and DRAIN and 0 in HOLD; imem_addr SHALL come from a fetch-address register latched on each new request.
REQ-018 In REQ, on ack with stall=0 and redirect=0: instr_out<=imem_rdata, pc_out<=fetch address, valid_out<=1, PC<=PC+4 (64-bit wrap), and the state SHALL stay REQ.
REQ-019 In REQ, on ack with stall=1 and redirect=0: word and address SHALL load into the skid buffer, PC<=PC+4, and the state SHALL go to HOLD; outputs SHALL be unchanged.
REQ-020 In REQ without ack: if stall=0, valid_out<=0 and instr_out<=NOP_INSTR; if stall=1, outputs SHALL hold.
REQ-021 In HOLD with stall=0: the skid buffer SHALL move to the outputs with valid_out<=1, the state SHALL go to REQ, and the next request SHALL be issued in the following cycle.
REQ-022 Redirect in any state SHALL set PC<=redirect_target, valid_out<=0, instr_out<=NOP_INSTR, pc_out unchanged, and clear the skid buffer, regardless of stall.
REQ-023 Redirect in REQ without ack SHALL go to DRAIN, keeping the old imem_addr; a redirect coincident with ack in REQ SHALL discard the data and go to REQ at the target.
REQ-024 In DRAIN, the ack SHALL be consumed with data discarded, then REQ issues at the redirected PC; a further redirect in DRAIN SHALL update PC only.
REQ-025 Latency SHALL be one cycle from ack to instr_out with zero-wait memory and no stall, sustaining one instruction per cycle.
REQ-026 redirect_target bits [1:0] SHALL be used as given, with no alignment fault checking.

Reset
REQ-027 While reset is high: PC=RESET_PC, state=REQ, imem_req=0, instr_out=NOP_INSTR, pc_out=0, valid_out=0, skid buffer cleared.
REQ-028 The first request SHALL issue in the first cycle after reset deasserts; reset mid-fetch SHALL abandon the fetch with no drain.

Structure
REQ-029 The shared package pipeline_pkg SHALL hold the NOP_INSTR default, the PC/instruction widths, and the fetch-state enum.
REQ-030 There SHALL be one sub-module, fetch_skid_buffer: a 96-bit holding register with load, clear and a valid flag; all other state lives in fetch_stage.

Verification
REQ-031 Release reset, zero-wait ack always high -> imem_addr 0,4,8,12; instr_out follows rdata one cycle later with valid_out=1.
REQ-032 Ack delayed 3 cycles at PC 8 -> imem_addr holds 8; valid_out=0 for 3 cycles; then instr at pc_out=8.
REQ-033 stall=1 for 2 cycles while ack arrives at PC 16 -> outputs frozen, state HOLD, imem_req=0; stall drops -> pc_out=16 valid, next imem_addr=20.
REQ-034 redirect to 0x100 while a fetch at 0x40 is pending, ack 2 cycles later -> 0x40 data never appears; next imem_addr=0x100.
REQ-035 redirect and stall both high -> valid_out=0 and instr_out=NOP_INSTR next cycle; PC=target.
REQ-036 Assert reset mid-HOLD -> all outputs reach reset values asynchronously; first post-reset imem_addr=RESET_PC.
